seven_segment_scan_decoder: RTL

//  Reader side of the multiplexed 7-segment display bus. Samples segment lines A..G plus
//  per-digit enables, waits for each pattern to be stable, and decodes it back to a 4-bit
//  hex value per digit. Used for display loopback checking and for capturing score digits

---
 rtl/seven_segment_scan_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scan_decoder.sv
// Reader side of a multiplexed 7-segment bus: synchronises segment/enable lines, waits for a
// stable pattern on a one-hot digit select and decodes it back to a per-digit hex value.
module seven_segment_scan_decoder #(
    parameter int NUM_DIGITS     = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [6:0]              i_Segments,
    input  logic [NUM_DIGITS-1:0]   i_Digit_En,
    output logic [4*NUM_DIGITS-1:0] o_Digits,
    output logic [NUM_DIGITS-1:0]   o_Digit_Valid,
    output logic                    o_Update,
    output logic [IW-1:0]           o_Update_Idx,
    output logic                    o_Error,
    output logic [7:0]              o_Err_Count
);
    // state  | meaning
    // IDLE   | digit select empty or multi-hot; nothing being tracked
    // TRACK  | counting consecutive identical samples of {seg,en}
    // HOLD   | current pattern already committed; wait for it to change

    localparam int PW = 7 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           stab_q, stab_d;
    logic [PW-1:0]           sync1_q, sync2_q, prev_q, pair;
    logic [NUM_DIGITS-1:0]   en;
    logic [6:0]              c_seg;
    logic [NUM_DIGITS-1:0]   c_en;
    logic [IW-1:0]           c_idx;
    logic                    commit;
    logic [3:0]              dec_val;
    logic                    dec_ok, dec_blank;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d, error_q, error_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    assign pair  = sync2_q ^ {PW{SEG_ACTIVE_LOW}};
    assign en    = pair[NUM_DIGITS-1:0];
    // prev_q holds the last sample; at commit time it is the pattern that proved stable
    assign c_seg = prev_q[PW-1:NUM_DIGITS];
    assign c_en  = prev_q[NUM_DIGITS-1:0];

    always_comb begin
        c_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (c_en[k]) c_idx = IW'(k);
        end
    end

    always_comb begin
        dec_val   = 4'h0;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        case (c_seg)
            7'h7E: dec_val = 4'h0;
            7'h30: dec_val = 4'h1;
            7'h6D: dec_val = 4'h2;
            7'h79: dec_val = 4'h3;
            7'h33: dec_val = 4'h4;
            7'h5B: dec_val = 4'h5;
            7'h5F: dec_val = 4'h6;
            7'h70: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h7B: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h1F: dec_val = 4'hB;
            7'h4E: dec_val = 4'hC;
            7'h3D: dec_val = 4'hD;
            7'h4F: dec_val = 4'hE;
            7'h47: dec_val = 4'hF;
            7'h00: begin dec_ok = 1'b0; dec_blank = 1'b1; end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ($onehot(en)) begin
                    state_d = S_TRACK;
                    stab_d  = CW'(1);
                end
            end
            S_TRACK: begin
                commit = (stab_q == CW'(STABLE_CYCLES));
                if (pair == prev_q) begin
                    if (commit) state_d = S_HOLD;
                    else        stab_d  = stab_q + CW'(1);
                end else if ($onehot(en)) begin
                    stab_d = CW'(1);
                end else begin
                    state_d = S_IDLE;
                    stab_d  = '0;
                end
            end
            S_HOLD: begin
                if (pair != prev_q) begin
                    if ($onehot(en)) begin
                        state_d = S_TRACK;
                        stab_d  = CW'(1);
                    end else begin
                        state_d = S_IDLE;
                        stab_d  = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                stab_d  = '0;
            end
        endcase
    end

    always_comb begin
        digits_d  = digits_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        update_d  = 1'b0;
        error_d   = 1'b0;
        if (commit) begin
            if (dec_ok) begin
                digits_d[4*c_idx +: 4] = dec_val;
                valid_d[c_idx]         = 1'b1;
                update_d               = 1'b1;
                idx_d                  = c_idx;
            end else if (dec_blank) begin
                valid_d[c_idx] = 1'b0;
                update_d       = 1'b1;
                idx_d          = c_idx;
            end else begin
                valid_d[c_idx] = 1'b0;
                error_d        = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            state_q   <= S_IDLE;
            stab_q    <= '0;
            digits_q  <= '0;
            valid_q   <= '0;
            update_q  <= 1'b0;
            error_q   <= 1'b0;
            idx_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            sync1_q   <= {i_Segments, i_Digit_En};
            sync2_q   <= sync1_q;
            prev_q    <= pair;
            state_q   <= state_d;
            stab_q    <= stab_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            update_q  <= update_d;
            error_q   <= error_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_Digits      = digits_q;
    assign o_Digit_Valid = valid_q;
    assign o_Update      = update_q;
    assign o_Update_Idx  = idx_q;
    assign o_Error       = error_q;
    assign o_Err_Count   = err_cnt_q;

endmodule
